// File: rtl/resp_misr.sv
// resp_misr: folds netlist response vectors into a MISR signature
// and compares the final value against a golden signature.
module resp_misr #(
  parameter int              WIDTH = 8,
  parameter int              SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SEED = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [15:0]      num_vec,
  input  logic [SIG_W-1:0] golden,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      vec_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      num_q;
  logic [SIG_W-1:0] golden_q;
  logic [SIG_W-1:0] data_ext;
  logic [SIG_W-1:0] sig_nxt;
  logic [15:0]      cnt_nxt;
  logic             beat;
  logic             last;
  logic             start_ok;

  assign in_ready = (state == RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  assign beat     = in_valid & in_ready;
  assign cnt_nxt  = vec_count + 16'd1;
  assign last     = beat & (cnt_nxt == num_q);
  assign start_ok = start & (state != RUN);

  always_comb begin
    data_ext = '0;
    data_ext[WIDTH-1:0] = in_data;
  end

  // Galois-style shift: msb out selects the polynomial feedback
  always_comb begin
    sig_nxt = {signature[SIG_W-2:0], 1'b0} ^ data_ext;
    if (signature[SIG_W-1]) begin
      sig_nxt = sig_nxt ^ POLY;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = (num_vec == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= SEED;
      vec_count <= '0;
      pass      <= 1'b0;
      num_q     <= '0;
      golden_q  <= '0;
    end else if (start_ok) begin
      num_q     <= num_vec;
      golden_q  <= golden;
      signature <= SEED;
      vec_count <= '0;
      pass      <= (num_vec == 16'd0) && (golden == SEED);
    end else if (beat) begin
      signature <= sig_nxt;
      vec_count <= cnt_nxt;
      if (last) begin
        pass <= (sig_nxt == golden_q);
      end
    end
  end

endmodule

// File: tb/tb_resp_misr.sv
// tb_resp_misr: randomized self-checking bench for resp_misr
// against an arithmetic model of the signature register.
module tb_resp_misr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_vec = '0;
  logic [15:0] golden = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [15:0] vec_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  resp_misr dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .num_vec(num_vec),
    .golden(golden),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .busy(busy),
    .done(done),
    .pass(pass),
    .signature(signature),
    .vec_count(vec_count)
  );

  // Signature as a number: double it, fold the overflow back in
  // through the polynomial, then add (xor) the vector.
  function automatic int unsigned ref_step(int unsigned s,
                                           int unsigned d);
    int unsigned t;
    t = s * 2;
    if (t >= 32'h10000) t = (t - 32'h10000) ^ 32'h1021;
    return t ^ d;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({signature, vec_count, done, busy, in_ready, pass} !==
        {16'hFFFF, 16'h0, 4'b0000}) begin
      n_bad++;
      $display("FAIL reset_hold: got sig=%h cnt=%0d d/b/r/p=%b%b%b%b want FFFF 0 0000",
               signature, vec_count, done, busy, in_ready, pass);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({signature, vec_count, done, busy, in_ready, pass} !==
        {16'hFFFF, 16'h0, 4'b0000}) begin
      n_bad++;
      $display("FAIL reset_idle: got sig=%h cnt=%0d d/b/r/p=%b%b%b%b want FFFF 0 0000",
               signature, vec_count, done, busy, in_ready, pass);
    end
  endtask

  task automatic test_two_vec;
    num_vec = 16'd2;
    golden = 16'hCF3A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({in_ready, busy, done, signature} !== {3'b110, 16'hFFFF}) begin
      n_bad++;
      $display("FAIL two_start: got r/b/d=%b%b%b sig=%h want 110 FFFF",
               in_ready, busy, done, signature);
    end
    in_valid = 1'b1;
    in_data = 8'h00;
    @(negedge clk);
    n_cmp++;
    if ({signature, vec_count} !== {16'hEFDF, 16'd1}) begin
      n_bad++;
      $display("FAIL two_beat1: got sig=%h cnt=%0d want EFDF 1",
               signature, vec_count);
    end
    in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({signature, vec_count, done, pass, in_ready, busy} !==
        {16'hCF3A, 16'd2, 4'b1100}) begin
      n_bad++;
      $display("FAIL two_done: got sig=%h cnt=%0d d/p/r/b=%b%b%b%b want CF3A 2 1100",
               signature, vec_count, done, pass, in_ready, busy);
    end
    in_valid = 1'b1;
    in_data = 8'($urandom);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({signature, vec_count, done, pass} !== {16'hCF3A, 16'd2, 2'b11}) begin
      n_bad++;
      $display("FAIL two_hold: got sig=%h cnt=%0d d/p=%b%b want CF3A 2 11",
               signature, vec_count, done, pass);
    end
  endtask

  task automatic test_stall;
    num_vec = 16'd2;
    golden = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      in_data = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if ({signature, vec_count, busy} !== {16'hEFDF, 16'd1, 1'b1}) begin
        n_bad++;
        $display("FAIL stall_gap%0d: got sig=%h cnt=%0d busy=%b want EFDF 1 1",
                 g, signature, vec_count, busy);
      end
    end
    in_valid = 1'b1;
    in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({signature, vec_count, done, pass} !== {16'hCF3A, 16'd2, 2'b10}) begin
      n_bad++;
      $display("FAIL stall_done: got sig=%h cnt=%0d d/p=%b%b want CF3A 2 10",
               signature, vec_count, done, pass);
    end
  endtask

  task automatic test_zero_len;
    logic [15:0] gl [2];
    gl[0] = 16'hFFFF;
    gl[1] = 16'(($urandom % 16'hFFFF));
    for (int k = 0; k < 2; k++) begin
      num_vec = 16'd0;
      golden = gl[k];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if ({done, in_ready, busy, pass, signature, vec_count} !==
          {3'b100, gl[k] == 16'hFFFF, 16'hFFFF, 16'd0}) begin
        n_bad++;
        $display("FAIL zero_len%0d: got d/r/b/p=%b%b%b%b sig=%h cnt=%0d want 100%b FFFF 0",
                 k, done, in_ready, busy, pass, signature, vec_count,
                 gl[k] == 16'hFFFF);
      end
    end
  endtask

  task automatic test_ignored_start_restart;
    logic [7:0]  v [5];
    int unsigned m;
    m = 32'hFFFF;
    for (int i = 0; i < 5; i++) begin
      v[i] = 8'($urandom);
      m = ref_step(m, v[i]);
    end
    num_vec = 16'd5;
    golden = 16'(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = v[i];
      start = (i == 2);
      if (i == 2) begin
        num_vec = 16'd1;
        golden = 16'h0000;
      end
      @(negedge clk);
      start = 1'b0;
      n_cmp++;
      if (vec_count !== 16'(i + 1)) begin
        n_bad++;
        $display("FAIL ign_start_cnt%0d: got %0d want %0d", i, vec_count, i + 1);
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({signature, done, pass} !== {16'(m), 2'b11}) begin
      n_bad++;
      $display("FAIL ign_start_done: got sig=%h d/p=%b%b want %h 11",
               signature, done, pass, 16'(m));
    end
    num_vec = 16'd1;
    golden = 16'hEFDF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h00;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({signature, vec_count, done, pass} !== {16'hEFDF, 16'd1, 2'b11}) begin
      n_bad++;
      $display("FAIL restart: got sig=%h cnt=%0d d/p=%b%b want EFDF 1 11",
               signature, vec_count, done, pass);
    end
  endtask

  task automatic test_midrun_reset;
    int unsigned m;
    logic [7:0]  d;
    m = 32'hFFFF;
    num_vec = 16'd100;
    golden = 16'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      in_data = d;
      m = ref_step(m, d);
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({signature, vec_count, busy} !== {16'(m), 16'd40, 1'b1}) begin
      n_bad++;
      $display("FAIL midrun_40: got sig=%h cnt=%0d busy=%b want %h 40 1",
               signature, vec_count, busy, 16'(m));
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({signature, vec_count, done, busy, in_ready, pass} !==
        {16'hFFFF, 16'h0, 4'b0000}) begin
      n_bad++;
      $display("FAIL midrun_rst: got sig=%h cnt=%0d d/b/r/p=%b%b%b%b want FFFF 0 0000",
               signature, vec_count, done, busy, in_ready, pass);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    num_vec = 16'd2;
    golden = 16'hCF3A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h00;
    @(negedge clk);
    in_data = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    n_cmp++;
    if ({signature, done, pass} !== {16'hCF3A, 2'b11}) begin
      n_bad++;
      $display("FAIL midrun_rerun: got sig=%h d/p=%b%b want CF3A 11",
               signature, done, pass);
    end
  endtask

  task automatic test_random_runs;
    logic [7:0]  v [$];
    int unsigned m;
    int          k;
    int          idx;
    int          cyc;
    logic        pv;
    logic        pr;
    logic [15:0] gl;
    for (int r = 0; r < 8; r++) begin
      k = $urandom_range(1, 24);
      v.delete();
      for (int i = 0; i < k; i++) v.push_back(8'($urandom));
      m = 32'hFFFF;
      for (int i = 0; i < k; i++) m = ref_step(m, v[i]);
      gl = ($urandom % 2 == 0) ? 16'(m) : 16'($urandom);
      num_vec = 16'(k);
      golden = gl;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      num_vec = 16'($urandom);
      golden = 16'($urandom);
      m = 32'hFFFF;
      idx = 0;
      pv = 1'b0;
      pr = 1'b0;
      cyc = 0;
      while (1) begin
        if (pv && pr) begin
          m = ref_step(m, v[idx]);
          idx++;
        end
        n_cmp++;
        if ({signature, done} !== {16'(m), idx == k}) begin
          n_bad++;
          $display("FAIL rand%0d_cyc%0d: got sig=%h done=%b want %h %b",
                   r, cyc, signature, done, 16'(m), idx == k);
        end
        if (done || idx >= k) break;
        if (cyc > 200) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rand%0d_timeout: got done=%b want 1", r, done);
          break;
        end
        in_valid = ($urandom % 4) != 0;
        in_data = in_valid ? v[idx] : 8'($urandom);
        pv = in_valid;
        pr = in_ready;
        @(negedge clk);
        cyc++;
      end
      in_valid = 1'b0;
      n_cmp++;
      if ({vec_count, pass, in_ready} !== {16'(k), 16'(m) == gl, 1'b0}) begin
        n_bad++;
        $display("FAIL rand%0d_final: got cnt=%0d pass=%b rdy=%b want %0d %b 0",
                 r, vec_count, pass, in_ready, k, 16'(m) == gl);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_two_vec();
    test_stall();
    test_zero_len();
    test_ignored_start_restart();
    test_midrun_reset();
    test_random_runs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
